// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit for the EXE stage.
// Multiplies by shift-add (MUL_BITS multiplier bits per cycle) and divides by
// restoring division (one quotient bit per cycle) on operand magnitudes. A
// final FIX cycle applies the sign and selects the result. Division by zero
// and signed overflow are resolved at acceptance and skip straight to DONE.
module muldiv_unit #(
  parameter int XLEN     = 64,
  parameter int MUL_BITS = 2,
  parameter int TAG_W    = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_word,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  // Counter start values: the iteration count minus one for each width.
  localparam logic [CNT_W-1:0] MUL_CNT_X = CNT_W'(XLEN / MUL_BITS - 1);
  localparam logic [CNT_W-1:0] MUL_CNT_W = CNT_W'(32 / MUL_BITS - 1);
  localparam logic [CNT_W-1:0] DIV_CNT_X = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] DIV_CNT_W = CNT_W'(31);
  localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t state_reg, state_next;

  // Latched operation context
  logic [2:0]       op_reg;
  logic             word_reg;
  logic [TAG_W-1:0] tag_reg;
  logic             neg1_reg, neg2_reg;
  logic [CNT_W-1:0] counter_reg;

  // Multiply datapath: multiplicand shifts left, multiplier shifts right
  logic [2*XLEN-1:0] mcand_reg;
  logic [XLEN-1:0]   mplier_reg;
  logic [2*XLEN-1:0] acc_reg;

  // Divide datapath: dividend bits shift out of quo_reg as quotient bits shift in
  logic [XLEN-1:0]   quo_reg;
  logic [XLEN-1:0]   rem_reg;
  logic [XLEN-1:0]   dvs_reg;

  // Acceptance-time decode
  logic              word_in, signed1, signed2, neg1, neg2;
  logic [XLEN-1:0]   src1_w, src2_w, neg1_full, neg2_full, mag1, mag2;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   dividend_ext, special_result;
  logic [CNT_W-1:0]  cnt_init;

  // Iteration and fix-up logic
  logic [2*XLEN-1:0] pp [MUL_BITS];
  logic [2*XLEN-1:0] pp_sum;
  logic              q_msb, q_ge;
  logic [XLEN:0]     r_shift, r_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    return XLEN'($signed(v[31:0]));
  endfunction

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);

  // Decode the presented request: effective width, signs, magnitudes, special cases.
  always_comb begin
    word_in   = in_word && (in_op == 3'd0 || in_op[2]);
    signed1   = (in_op == 3'd0) || (in_op == 3'd1) || (in_op == 3'd2) ||
                (in_op == 3'd4) || (in_op == 3'd6);
    signed2   = (in_op == 3'd0) || (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);
    src1_w    = word_in ? XLEN'(in_src1[31:0]) : in_src1;
    src2_w    = word_in ? XLEN'(in_src2[31:0]) : in_src2;
    neg1      = signed1 && (word_in ? in_src1[31] : in_src1[XLEN-1]);
    neg2      = signed2 && (word_in ? in_src2[31] : in_src2[XLEN-1]);
    neg1_full = -src1_w;
    neg2_full = -src2_w;
    mag1      = neg1 ? (word_in ? XLEN'(neg1_full[31:0]) : neg1_full) : src1_w;
    mag2      = neg2 ? (word_in ? XLEN'(neg2_full[31:0]) : neg2_full) : src2_w;
    div_zero  = in_op[2] && (src2_w == '0);
    div_ovf   = in_op[2] && !in_op[0] &&
                (word_in ? (in_src1[31:0] == 32'h8000_0000 && in_src2[31:0] == 32'hFFFF_FFFF)
                         : (in_src1 == MOST_NEG && in_src2 == '1));
    special   = div_zero || div_ovf;
    dividend_ext = word_in ? sext32(in_src1) : in_src1;
    if (div_zero) begin
      special_result = in_op[1] ? dividend_ext : '1;
    end else begin
      special_result = in_op[1] ? '0 : dividend_ext;
    end
    if (in_op[2]) begin
      cnt_init = word_in ? DIV_CNT_W : DIV_CNT_X;
    end else begin
      cnt_init = word_in ? MUL_CNT_W : MUL_CNT_X;
    end
  end

  // One shifted copy of the multiplicand per multiplier bit retired this cycle.
  generate
    for (genvar gi = 0; gi < MUL_BITS; gi++) begin : g_pp
      assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
    end
  endgenerate

  // Sum the partial products of this cycle.
  always_comb begin
    pp_sum = '0;
    for (int i = 0; i < MUL_BITS; i++) begin
      pp_sum = pp_sum + pp[i];
    end
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    q_msb   = word_reg ? quo_reg[31] : quo_reg[XLEN-1];
    r_shift = {rem_reg, q_msb};
    r_diff  = r_shift - {1'b0, dvs_reg};
    q_ge    = !r_diff[XLEN];
  end

  // Apply operand signs to the unsigned result and pick the architectural result.
  always_comb begin
    prod_fix = (neg1_reg ^ neg2_reg) ? -acc_reg : acc_reg;
    quo_fix  = (neg1_reg ^ neg2_reg) ? -quo_reg : quo_reg;
    rem_fix  = neg1_reg ? -rem_reg : rem_reg;
    case (op_reg)
      3'd0:          fix_result = word_reg ? sext32(prod_fix[XLEN-1:0]) : prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fix_result = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:    fix_result = word_reg ? sext32(quo_fix) : quo_fix;
      default:       fix_result = word_reg ? sext32(rem_fix) : rem_fix;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            if (special) begin
              state_next = DONE;
            end else begin
              state_next = in_op[2] ? DIV : MUL;
            end
          end
        end
        MUL, DIV: begin
          if (counter_reg == '0) begin
            state_next = FIX;
          end
        end
        FIX: state_next = DONE;
        DONE: begin
          if (out_ready) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath: latch on acceptance, iterate in MUL/DIV, load outputs on entry to DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_reg      <= '0;
      word_reg    <= 1'b0;
      tag_reg     <= '0;
      neg1_reg    <= 1'b0;
      neg2_reg    <= 1'b0;
      counter_reg <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      dvs_reg     <= '0;
      out_result  <= '0;
      out_tag     <= '0;
    end else begin
      if (state_reg == IDLE && in_valid && !flush) begin
        op_reg      <= in_op;
        word_reg    <= word_in;
        tag_reg     <= in_tag;
        neg1_reg    <= neg1;
        neg2_reg    <= neg2;
        counter_reg <= cnt_init;
        mcand_reg   <= {{XLEN{1'b0}}, mag1};
        mplier_reg  <= mag2;
        acc_reg     <= '0;
        quo_reg     <= mag1;
        rem_reg     <= '0;
        dvs_reg     <= mag2;
      end
      if (state_reg == MUL) begin
        acc_reg    <= acc_reg + pp_sum;
        mcand_reg  <= mcand_reg << MUL_BITS;
        mplier_reg <= mplier_reg >> MUL_BITS;
      end
      if (state_reg == DIV) begin
        quo_reg <= {quo_reg[XLEN-2:0], q_ge};
        rem_reg <= q_ge ? r_diff[XLEN-1:0] : r_shift[XLEN-1:0];
      end
      if ((state_reg == MUL || state_reg == DIV) && counter_reg != '0) begin
        counter_reg <= counter_reg - 1'b1;
      end
      if (state_next == DONE && state_reg != DONE) begin
        out_result <= (state_reg == FIX) ? fix_result : special_result;
        out_tag    <= (state_reg == FIX) ? tag_reg : in_tag;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed vector table, hand-written multi-cycle
// sequences (backpressure, flush, reset) and random operations against a
// plain-arithmetic reference model, across four parameterisations.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic [2:0]  in_op;
  logic        in_word;
  logic [63:0] in_src1, in_src2;
  logic [4:0]  in_tag;
  logic        iv   [4];
  logic        ordy [4];

  logic        ir0, ir1, ir2, ir3, ov0, ov1, ov2, ov3;
  logic [63:0] res0, res1, res2;
  logic [31:0] res3;
  logic [4:0]  tg0, tg1, tg2, tg3;

  logic        ir_a  [4];
  logic        ov_a  [4];
  logic [63:0] res_a [4];
  logic [4:0]  tg_a  [4];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  muldiv_unit #(.XLEN(64), .MUL_BITS(2), .TAG_W(5)) u_dut0 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(iv[0]), .in_ready(ir0),
    .in_op(in_op), .in_word(in_word), .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .out_valid(ov0), .out_ready(ordy[0]), .out_result(res0), .out_tag(tg0));

  muldiv_unit #(.XLEN(64), .MUL_BITS(1), .TAG_W(5)) u_dut1 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(iv[1]), .in_ready(ir1),
    .in_op(in_op), .in_word(in_word), .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .out_valid(ov1), .out_ready(ordy[1]), .out_result(res1), .out_tag(tg1));

  muldiv_unit #(.XLEN(64), .MUL_BITS(4), .TAG_W(5)) u_dut2 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(iv[2]), .in_ready(ir2),
    .in_op(in_op), .in_word(in_word), .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .out_valid(ov2), .out_ready(ordy[2]), .out_result(res2), .out_tag(tg2));

  muldiv_unit #(.XLEN(32), .MUL_BITS(2), .TAG_W(5)) u_dut3 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(iv[3]), .in_ready(ir3),
    .in_op(in_op), .in_word(in_word), .in_src1(in_src1[31:0]), .in_src2(in_src2[31:0]),
    .in_tag(in_tag), .out_valid(ov3), .out_ready(ordy[3]), .out_result(res3), .out_tag(tg3));

  always_comb begin
    ir_a[0] = ir0; ir_a[1] = ir1; ir_a[2] = ir2; ir_a[3] = ir3;
    ov_a[0] = ov0; ov_a[1] = ov1; ov_a[2] = ov2; ov_a[3] = ov3;
    res_a[0] = res0; res_a[1] = res1; res_a[2] = res2; res_a[3] = {32'h0, res3};
    tg_a[0] = tg0; tg_a[1] = tg1; tg_a[2] = tg2; tg_a[3] = tg3;
  end

  function automatic int xlen_of(input int d);
    return (d == 3) ? 32 : 64;
  endfunction

  function automatic int mbits_of(input int d);
    return (d == 1) ? 1 : ((d == 2) ? 4 : 2);
  endfunction

  function automatic int eff_w(input int xlen, input logic [2:0] op, input logic word);
    return (word && (op == 3'd0 || op >= 3'd4)) ? 32 : xlen;
  endfunction

  // Reference result from plain wide signed/unsigned arithmetic.
  function automatic logic [63:0] model(input int xlen, input logic [2:0] op, input logic word,
                                        input logic [63:0] a, input logic [63:0] b);
    int w;
    logic [127:0] ua, ub, umask;
    logic signed [127:0] sa, sb, r;
    logic [63:0] res, m;
    w = eff_w(xlen, op, word);
    umask = (128'd1 << w) - 128'd1;
    ua = {64'd0, a} & umask;
    ub = {64'd0, b} & umask;
    sa = ua;
    sb = ub;
    if (ua[w-1]) sa = sa - (128'sd1 <<< w);
    if (ub[w-1]) sb = sb - (128'sd1 <<< w);
    case (op)
      3'd0: r = sa * sb;
      3'd1: r = (sa * sb) >>> w;
      3'd2: r = (sa * $signed(ub)) >>> w;
      3'd3: r = (ua * ub) >> w;
      3'd4: r = (ub == 0) ? -128'sd1 : sa / sb;
      3'd5: r = (ub == 0) ? -128'sd1 : ua / ub;
      3'd6: r = (ub == 0) ? sa : sa % sb;
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    res = r[63:0] & m;
    if (res[w-1]) res = res | ~m;
    if (xlen == 32) res = res & 64'h0000_0000_FFFF_FFFF;
    return res;
  endfunction

  // Reference latency in edges from (and including) the accepting edge.
  function automatic int lat_model(input int xlen, input int mb, input logic [2:0] op,
                                   input logic word, input logic [63:0] a, input logic [63:0] b);
    int w;
    logic [63:0] m, aw, bw;
    w = eff_w(xlen, op, word);
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    aw = a & m;
    bw = b & m;
    if (op < 3'd4) return w / mb + 2;
    if (bw == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && aw == (64'd1 << (w - 1)) && bw == m) return 1;
    return w + 2;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called just after the accepting edge; counts edges until out_valid rises.
  task automatic wait_result(input int d, output logic [63:0] got, output logic [4:0] gtag,
                             output int lat);
    lat = 1;
    while (!ov_a[d] && lat < 300) begin
      @(posedge clock);
      #1;
      lat++;
    end
    if (!ov_a[d]) chk("result_timeout", 64'(ov_a[d]), 64'd1);
    got  = res_a[d];
    gtag = tg_a[d];
  endtask

  task automatic run_op(input int d, input logic [2:0] op, input logic word,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag,
                        input logic [63:0] exp, input int exp_lat);
    logic [63:0] got;
    logic [4:0]  gtag;
    int          lat;
    @(negedge clock);
    chk("in_ready_before_issue", 64'(ir_a[d]), 64'd1);
    in_op = op; in_word = word; in_src1 = a; in_src2 = b; in_tag = tag;
    iv[d] = 1'b1;
    @(posedge clock);
    #1;
    iv[d] = 1'b0;
    wait_result(d, got, gtag, lat);
    $display("txn dut%0d op=%0d word=%0d a=%h b=%h result=%h tag=%0d lat=%0d",
             d, op, word, a, b, got, gtag, lat);
    chk("result", got, exp);
    chk("tag", 64'(gtag), 64'(tag));
    chk("latency", 64'(lat), 64'(exp_lat));
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  tag;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [18];

  initial begin
    logic [63:0] got, a, b;
    logic [4:0]  gtag, tag;
    logic [2:0]  op;
    logic        word;
    int          lat, sel, xl;
    logic        seen;

    vecs[0]  = '{3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd1, 64'hFFFF_FFFF_FFFF_FFEB, 34};
    vecs[1]  = '{3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34};
    vecs[2]  = '{3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 34};
    vecs[3]  = '{3'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFD, 34};
    vecs[4]  = '{3'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 34};
    vecs[5]  = '{3'd5, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 5'd6, 64'hFFFF_FFFF_8000_0000, 34};
    vecs[6]  = '{3'd4, 1'b0, 64'd5, 64'd0, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[7]  = '{3'd6, 1'b0, 64'd5, 64'd0, 5'd8, 64'd5, 1};
    vecs[8]  = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 64'h8000_0000_0000_0000, 1};
    vecs[9]  = '{3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10, 64'd0, 1};
    vecs[10] = '{3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd11, 64'hFFFF_FFFF_FFFF_FFFE, 18};
    vecs[11] = '{3'd5, 1'b0, 64'd100, 64'd7, 5'd12, 64'd14, 66};
    vecs[12] = '{3'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13, 64'd0, 34};
    vecs[13] = '{3'd7, 1'b1, 64'h0000_0001_FFFF_FFFF, 64'h10, 5'd14, 64'hF, 34};
    vecs[14] = '{3'd4, 1'b1, 64'h0000_0001_8000_0000, 64'h0000_0001_0000_0000, 5'd15, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[15] = '{3'd6, 1'b1, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd16, 64'd0, 1};
    vecs[16] = '{3'd4, 1'b1, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd17, 64'hFFFF_FFFF_8000_0000, 1};
    vecs[17] = '{3'd6, 1'b1, 64'h0000_0001_8000_0000, 64'h0000_0001_0000_0000, 5'd18, 64'hFFFF_FFFF_8000_0000, 1};

    reset = 1'b1; flush = 1'b0;
    in_op = '0; in_word = 1'b0; in_src1 = '0; in_src2 = '0; in_tag = '0;
    for (int i = 0; i < 4; i++) begin
      iv[i] = 1'b0;
      ordy[i] = 1'b1;
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("reset_in_ready", 64'(ir0), 64'd1);
    chk("reset_out_valid", 64'(ov0), 64'd0);
    chk("reset_out_result", res0, 64'd0);
    chk("reset_out_tag", 64'(tg0), 64'd0);
    chk("reset_in_ready_x32", 64'(ir3), 64'd1);

    // Directed table on the default configuration
    for (int i = 0; i < 18; i++) begin
      run_op(0, vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b, vecs[i].tag,
             vecs[i].exp, vecs[i].lat);
    end

    // Backpressure, then a request presented during the handshake cycle
    @(negedge clock);
    in_op = 3'd0; in_word = 1'b0; in_src1 = 64'd7; in_src2 = 64'hFFFF_FFFF_FFFF_FFFD;
    in_tag = 5'd12; iv[0] = 1'b1; ordy[0] = 1'b0;
    @(posedge clock);
    #1;
    iv[0] = 1'b0;
    wait_result(0, got, gtag, lat);
    chk("bp_latency", 64'(lat), 64'd34);
    for (int k = 0; k < 5; k++) begin
      chk("bp_result_stable", res0, 64'hFFFF_FFFF_FFFF_FFEB);
      chk("bp_tag_stable", 64'(tg0), 64'd12);
      chk("bp_in_ready_low", 64'(ir0), 64'd0);
      chk("bp_out_valid_high", 64'(ov0), 64'd1);
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    ordy[0] = 1'b1;
    in_op = 3'd5; in_word = 1'b0; in_src1 = 64'd100; in_src2 = 64'd7; in_tag = 5'd9;
    iv[0] = 1'b1;
    @(posedge clock);
    #1;
    chk("handshake_out_valid", 64'(ov0), 64'd0);
    chk("handshake_no_reaccept", 64'(ir0), 64'd1);
    @(posedge clock);
    #1;
    chk("next_accept", 64'(ir0), 64'd0);
    iv[0] = 1'b0;
    wait_result(0, got, gtag, lat);
    chk("after_bp_result", got, 64'd14);
    chk("after_bp_tag", 64'(gtag), 64'd9);
    chk("after_bp_latency", 64'(lat), 64'd66);
    @(posedge clock);
    #1;

    // Flush during MUL on the 10th edge after acceptance
    @(negedge clock);
    in_op = 3'd0; in_word = 1'b0; in_src1 = 64'd3; in_src2 = 64'd5; in_tag = 5'd20;
    iv[0] = 1'b1;
    @(posedge clock);
    #1;
    iv[0] = 1'b0;
    repeat (8) @(posedge clock);
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    chk("flush_mul_out_valid", 64'(ov0), 64'd0);
    chk("flush_mul_in_ready", 64'(ir0), 64'd1);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (ov0) seen = 1'b1;
    end
    chk("flush_mul_no_result", 64'(seen), 64'd0);

    // Request presented together with flush must not be accepted
    @(negedge clock);
    in_op = 3'd0; in_src1 = 64'd2; in_src2 = 64'd2; in_tag = 5'd22;
    iv[0] = 1'b1; flush = 1'b1;
    @(posedge clock);
    #1;
    chk("flush_blocks_accept", 64'(ir0), 64'd1);
    iv[0] = 1'b0; flush = 1'b0;

    // Flush in DONE with out_ready high discards the result
    @(negedge clock);
    in_op = 3'd4; in_word = 1'b0; in_src1 = 64'd5; in_src2 = 64'd0; in_tag = 5'd23;
    iv[0] = 1'b1; ordy[0] = 1'b0;
    @(posedge clock);
    #1;
    iv[0] = 1'b0;
    chk("done_reached", 64'(ov0), 64'd1);
    @(negedge clock);
    flush = 1'b1; ordy[0] = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    chk("flush_done_out_valid", 64'(ov0), 64'd0);
    chk("flush_done_in_ready", 64'(ir0), 64'd1);
    run_op(0, 3'd0, 1'b0, 64'd6, 64'd7, 5'd21, 64'd42, 34);

    // Reset in the middle of an operation
    @(negedge clock);
    in_op = 3'd0; in_word = 1'b0; in_src1 = 64'd9; in_src2 = 64'd9; in_tag = 5'd25;
    iv[0] = 1'b1;
    @(posedge clock);
    #1;
    iv[0] = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("midreset_out_valid", 64'(ov0), 64'd0);
    chk("midreset_in_ready", 64'(ir0), 64'd1);
    chk("midreset_out_result", res0, 64'd0);
    chk("midreset_out_tag", 64'(tg0), 64'd0);

    // Random operations on every configuration against the reference model
    for (int d = 0; d < 4; d++) begin
      xl = xlen_of(d);
      for (int n = 0; n < 25; n++) begin
        op   = 3'($urandom_range(0, 7));
        word = 1'($urandom_range(0, 1));
        a    = {$urandom, $urandom};
        b    = {$urandom, $urandom};
        tag  = 5'($urandom_range(0, 31));
        sel  = $urandom_range(0, 7);
        if (sel == 0) b = 64'd0;
        if (sel == 1) begin
          b = '1;
          a = (word || xl == 32) ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
        end
        if (sel == 2) begin
          a = 64'($urandom_range(0, 20));
          b = 64'($urandom_range(0, 20));
        end
        if (sel == 3) b = 64'($urandom_range(1, 9));
        run_op(d, op, word, a, b, tag, model(xl, op, word, a, b),
               lat_model(xl, mbits_of(d), op, word, a, b));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
